// File: rtl/data_sram_resp.sv
// Single-outstanding data-port responder over a word RAM. data_ok arrives LATENCY cycles after accept.
// addr_ok drops while a request waits; a new request can be taken in the response cycle.
module data_sram_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    localparam int AW = DEPTH_LOG2;
    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t          state_q;
    logic [2:0]      cnt_q;
    logic            wr_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     wdata_q;
    logic            data_ok_q;
    logic            resp_err_q;
    logic [31:0]     rdata_q;

    logic [31:0]     mem [0:(1<<AW)-1];

    logic            accept;
    logic            enter_resp;
    logic            req_err;
    logic            cur_wr;
    logic            cur_err;
    logic [AW-1:0]   cur_idx;
    logic [3:0]      cur_wstrb;
    logic [31:0]     cur_wdata;
    logic            unused_addr;

    assign unused_addr = ^addr[31:AW+2];

    always_comb begin
        req_err = 1'b0;
        case (size)
            2'd0:    req_err = wr && (wstrb != (4'b0001 << addr[1:0]));
            2'd1:    req_err = addr[0] || (wr && (wstrb != (addr[1] ? 4'b1100 : 4'b0011)));
            2'd2:    req_err = (addr[1:0] != 2'b00) || (wr && (wstrb != 4'b1111));
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        addr_ok    = (state_q != WAIT);
        busy       = (state_q != IDLE);
        accept     = req && addr_ok;
        enter_resp = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == 3'd0));
        // With LATENCY=1 the commit happens on the accepting edge, before the latch holds it.
        if (state_q == WAIT) begin
            cur_wr    = wr_q;
            cur_err   = err_q;
            cur_idx   = idx_q;
            cur_wstrb = wstrb_q;
            cur_wdata = wdata_q;
        end else begin
            cur_wr    = wr;
            cur_err   = req_err;
            cur_idx   = addr[AW+1:2];
            cur_wstrb = wstrb;
            cur_wdata = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wstrb_q    <= 4'd0;
            wdata_q    <= 32'd0;
            data_ok_q  <= 1'b0;
            resp_err_q <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            if (accept) begin
                wr_q    <= wr;
                err_q   <= req_err;
                idx_q   <= addr[AW+1:2];
                wstrb_q <= wstrb;
                wdata_q <= wdata;
                if (LATENCY == 1) begin
                    state_q <= RESP;
                end else begin
                    state_q <= WAIT;
                    cnt_q   <= CNT_INIT;
                end
            end else begin
                case (state_q)
                    WAIT: begin
                        if (cnt_q == 3'd0) state_q <= RESP;
                        else               cnt_q   <= cnt_q - 3'd1;
                    end
                    RESP:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
            data_ok_q  <= enter_resp;
            resp_err_q <= enter_resp && cur_err;
            if (enter_resp) begin
                rdata_q <= (cur_wr || cur_err) ? 32'd0 : mem[cur_idx];
            end
        end
    end

    // RAM is never reset; the rst gate keeps an aborted store from landing.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && cur_wr && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end

    assign data_ok  = data_ok_q;
    assign resp_err = resp_err_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: LATENCY=2 and LATENCY=1 instances share one stimulus bus.
module tb_data_sram_resp;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, wr, sel;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;

    logic        addr_ok2, data_ok2, resp_err2, busy2;
    logic [31:0] rdata2;
    logic        addr_ok1, data_ok1, resp_err1, busy1;
    logic [31:0] rdata1;

    exp_t q2[$];
    exp_t q1[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .req(req && !sel), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok2), .data_ok(data_ok2),
        .rdata(rdata2), .resp_err(resp_err2), .busy(busy2)
    );

    data_sram_resp #(.DEPTH_LOG2(10), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .req(req && sel), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok1), .data_ok(data_ok1),
        .rdata(rdata1), .resp_err(resp_err1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (data_ok2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL l2_unexpected_data_ok actual=1 expected=0");
            end else begin
                e = q2.pop_front();
                chk("l2_rdata", rdata2, e.rdata);
                chk("l2_resp_err", {31'd0, resp_err2}, {31'd0, e.err});
                chk("l2_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (data_ok1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL l1_unexpected_data_ok actual=1 expected=0");
            end else begin
                e = q1.pop_front();
                chk("l1_rdata", rdata1, e.rdata);
                chk("l1_resp_err", {31'd0, resp_err1}, {31'd0, e.err});
                chk("l1_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Applies a request, waits for acceptance and records the expected response.
    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d,
                         input logic [31:0] er, input logic ee);
        logic ok;
        exp_t e;
        wr = w; size = sz; addr = a; wstrb = s; wdata = d; req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel ? addr_ok1 : addr_ok2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL accept_timeout actual=0 expected=1 addr=%h", a);
        end else begin
            e.rdata = er;
            e.err   = ee;
            e.cyc   = cyc + (sel ? 1 : 2);
            if (sel) q1.push_back(e);
            else     q2.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        logic empty;
        req = 1'b0;
        empty = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q1.size() == 0 && q2.size() == 0) begin
                empty = 1'b1;
                break;
            end
        end
        if (!empty) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d expected=0", q1.size() + q2.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; wr = 1'b0; sel = 1'b0;
        size = 2'd0; addr = 32'd0; wstrb = 4'd0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_ok", {31'd0, data_ok2}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err2}, 32'd0);
        chk("rst_rdata", rdata2, 32'd0);
        chk("rst_addr_ok", {31'd0, addr_ok2}, 32'd1);
        chk("rst_busy", {31'd0, busy2}, 32'd0);
        chk("rst_l1_data_ok", {31'd0, data_ok1}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // LATENCY=2 directed sequence
        issue(1, 2'd2, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 2'd2, 32'h100, 4'h0, 32'h0,       32'hDEADBEEF, 0);
        issue(1, 2'd0, 32'h102, 4'h4, 32'h00550000, 32'h0, 0);
        issue(0, 2'd2, 32'h100, 4'h0, 32'h0,       32'hDE55BEEF, 0);
        issue(1, 2'd2, 32'h104, 4'hF, 32'hCAFEF00D, 32'h0, 0);
        issue(0, 2'd1, 32'h101, 4'h0, 32'h0,       32'h0, 1);
        issue(1, 2'd2, 32'h106, 4'hF, 32'h12345678, 32'h0, 1);
        issue(0, 2'd2, 32'h104, 4'h0, 32'h0,       32'hCAFEF00D, 0);
        issue(1, 2'd2, 32'h104, 4'h3, 32'hFFFFFFFF, 32'h0, 1);
        issue(0, 2'd2, 32'h104, 4'h0, 32'h0,       32'hCAFEF00D, 0);
        issue(1, 2'd2, 32'h108, 4'hF, 32'h01020304, 32'h0, 0);
        issue(1, 2'd1, 32'h10A, 4'hC, 32'hABCD0000, 32'h0, 0);
        issue(1, 2'd0, 32'h109, 4'h1, 32'h000000EE, 32'h0, 1);
        issue(1, 2'd3, 32'h108, 4'hF, 32'h0,       32'h0, 1);
        issue(0, 2'd2, 32'h108, 4'h0, 32'h0,       32'hABCD0304, 0);
        issue(0, 2'd2, 32'h1100, 4'h0, 32'h0,      32'hDE55BEEF, 0);
        issue(1, 2'd2, 32'h200, 4'hF, 32'h11112222, 32'h0, 0);
        issue(0, 2'd2, 32'h200, 4'h0, 32'h0,       32'h11112222, 0);
        drain();

        // Reset while a store to 0x200 waits
        wr = 1'b1; size = 2'd2; addr = 32'h200; wstrb = 4'hF; wdata = 32'h99999999; req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        req = 1'b0;
        chk("wait_addr_ok", {31'd0, addr_ok2}, 32'd0);
        chk("wait_busy", {31'd0, busy2}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_data_ok", {31'd0, data_ok2}, 32'd0);
        chk("abort_addr_ok", {31'd0, addr_ok2}, 32'd1);
        chk("abort_busy", {31'd0, busy2}, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        issue(0, 2'd2, 32'h200, 4'h0, 32'h0, 32'h11112222, 0);
        issue(0, 2'd2, 32'h100, 4'h0, 32'h0, 32'hDE55BEEF, 0);
        drain();

        // LATENCY=1 back-to-back traffic with req held high
        sel = 1'b1;
        issue(1, 2'd2, 32'h000, 4'hF, 32'hA0A0A0A0, 32'h0, 0);
        issue(1, 2'd2, 32'h004, 4'hF, 32'hB1B1B1B1, 32'h0, 0);
        issue(1, 2'd2, 32'h008, 4'hF, 32'hC2C2C2C2, 32'h0, 0);
        issue(1, 2'd2, 32'h00C, 4'hF, 32'hD3D3D3D3, 32'h0, 0);
        issue(0, 2'd2, 32'h000, 4'h0, 32'h0, 32'hA0A0A0A0, 0);
        issue(0, 2'd2, 32'h004, 4'h0, 32'h0, 32'hB1B1B1B1, 0);
        issue(0, 2'd2, 32'h008, 4'h0, 32'h0, 32'hC2C2C2C2, 0);
        issue(0, 2'd2, 32'h00C, 4'h0, 32'h0, 32'hD3D3D3D3, 0);
        issue(1, 2'd2, 32'h010, 4'hF, 32'h77777777, 32'h0, 0);
        issue(0, 2'd2, 32'h010, 4'h0, 32'h0, 32'h77777777, 0);
        issue(1, 2'd2, 32'h014, 4'h3, 32'h55555555, 32'h0, 1);
        issue(0, 2'd0, 32'h00D, 4'h0, 32'h0, 32'hD3D3D3D3, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
